// File: rtl/municao_ctrl.sv
// municao_ctrl: magazine, single in-flight projectile and reload timer, all stepped on frame_tick
module municao_ctrl #(
  parameter int MAG_SIZE      = 5,
  parameter int SHOT_SPEED    = 4,
  parameter int Y_START       = 489,
  parameter int Y_TOP         = 3,
  parameter int X_MIN         = 97,
  parameter int X_MAX         = 784,
  parameter int RELOAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic        reload_btn,
  input  logic [10:0] player_x,
  input  logic        hit,
  output logic        shot_active,
  output logic [10:0] shot_x,
  output logic [9:0]  shot_y,
  output logic [3:0]  ammo,
  output logic        reloading,
  output logic [7:0]  score
);
  typedef enum logic [1:0] {IDLE, FLIGHT, RELOAD} state_t;
  localparam int CW = RELOAD_FRAMES > 1 ? $clog2(RELOAD_FRAMES) : 1;
  localparam logic [3:0]    MAG  = 4'(MAG_SIZE);
  localparam logic [9:0]    YS   = 10'(Y_START);
  localparam logic [9:0]    SPD  = 10'(SHOT_SPEED);
  localparam logic [9:0]    YMIS = 10'(Y_TOP + SHOT_SPEED);
  localparam logic [10:0]   XMN  = 11'(X_MIN);
  localparam logic [10:0]   XMX  = 11'(X_MAX);
  localparam logic [CW-1:0] CLST = CW'(RELOAD_FRAMES - 1);
  state_t state, state_n;
  logic fire_q, rel_q, fire_pend, rel_pend, hit_pend;
  logic fire_e, rel_e, hit_e;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] ammo_n;
  logic [10:0] shot_x_n, x_clamp;
  logic [9:0] shot_y_n;
  logic [7:0] score_n;
  // an edge arriving on the tick cycle itself still counts for that tick
  assign fire_e = fire_pend | (fire & ~fire_q);
  assign rel_e = rel_pend | (reload_btn & ~rel_q);
  assign hit_e = hit_pend | (hit & (state == FLIGHT));
  assign x_clamp = player_x < XMN ? XMN : (player_x > XMX ? XMX : player_x);
  assign shot_active = state == FLIGHT;
  assign reloading = state == RELOAD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fire_q <= 1'b0;
      rel_q <= 1'b0;
      fire_pend <= 1'b0;
      rel_pend <= 1'b0;
      hit_pend <= 1'b0;
      cnt <= '0;
      ammo <= MAG;
      shot_x <= '0;
      shot_y <= YS;
      score <= '0;
    end else begin
      state <= state_n;
      fire_q <= fire;
      rel_q <= reload_btn;
      fire_pend <= fire_e & ~frame_tick;
      rel_pend <= rel_e & ~frame_tick;
      hit_pend <= hit_e & ~frame_tick;
      cnt <= cnt_n;
      ammo <= ammo_n;
      shot_x <= shot_x_n;
      shot_y <= shot_y_n;
      score <= score_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ammo_n = ammo;
    shot_x_n = shot_x;
    shot_y_n = shot_y;
    score_n = score;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (fire_e && ammo != 4'd0) begin
            state_n = FLIGHT;
            shot_x_n = x_clamp;
            shot_y_n = YS;
            ammo_n = ammo - 4'd1;
          end else if (rel_e && ammo < MAG) begin
            state_n = RELOAD;
            cnt_n = '0;
          end
        end
        FLIGHT: begin
          if (hit_e || shot_y < YMIS) begin
            state_n = ammo == 4'd0 ? RELOAD : IDLE;
            cnt_n = '0;
            shot_y_n = YS;
            score_n = hit_e ? (score == 8'hFF ? score : score + 8'd1) : score;
          end else begin
            shot_y_n = shot_y - SPD;
          end
        end
        RELOAD: begin
          cnt_n = cnt + CW'(1);
          if (cnt == CLST) begin
            state_n = IDLE;
            ammo_n = MAG;
            cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_municao_ctrl.sv
// tb_municao_ctrl: directed checks of firing, flight, hits, clamping and reload timing
module tb_municao_ctrl;
  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, fire = 1'b0, reload_btn = 1'b0, hit = 1'b0;
  logic [10:0] player_x = 11'd300;
  logic shot_active, reloading;
  logic [10:0] shot_x;
  logic [9:0] shot_y;
  logic [3:0] ammo;
  logic [7:0] score;
  int checks = 0, errors = 0;

  municao_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire), .reload_btn(reload_btn),
    .player_x(player_x), .hit(hit), .shot_active(shot_active), .shot_x(shot_x),
    .shot_y(shot_y), .ammo(ammo), .reloading(reloading), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic r, input logic h);
    @(negedge clk) begin fire = f; reload_btn = r; hit = h; end
    @(negedge clk) begin fire = 1'b0; reload_btn = 1'b0; hit = 1'b0; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_active"}, int'(shot_active), 0);
    chk({tag, "_x"}, int'(shot_x), 0);
    chk({tag, "_y"}, int'(shot_y), 489);
    chk({tag, "_ammo"}, int'(ammo), 5);
    chk({tag, "_reloading"}, int'(reloading), 0);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");
    // launch
    pulse(1, 0, 0);
    tick();
    chk("launch_active", int'(shot_active), 1);
    chk("launch_x", int'(shot_x), 300);
    chk("launch_y", int'(shot_y), 489);
    chk("launch_ammo", int'(ammo), 4);
    // full flight without hit; a fire edge mid-flight is discarded
    for (int i = 1; i <= 121; i++) begin
      if (i == 50) begin player_x = 11'd600; pulse(1, 1, 0); end
      tick();
      chk("fly_y", int'(shot_y), 489 - 4 * i);
      chk("fly_active", int'(shot_active), 1);
    end
    chk("fly_x_held", int'(shot_x), 300);
    chk("fly_ammo", int'(ammo), 4);
    tick();
    chk("miss_active", int'(shot_active), 0);
    chk("miss_y", int'(shot_y), 489);
    chk("miss_score", int'(score), 0);
    chk("miss_reloading", int'(reloading), 0);
    tick();
    chk("no_stale_fire", int'(shot_active), 0);
    // hit mid-flight
    pulse(1, 0, 0);
    tick();
    chk("f2_ammo", int'(ammo), 3);
    tick();
    chk("f2_y", int'(shot_y), 485);
    pulse(0, 0, 1);
    chk("hit_pending_y", int'(shot_y), 485);
    tick();
    chk("hit_active", int'(shot_active), 0);
    chk("hit_score", int'(score), 1);
    pulse(0, 0, 1);
    tick();
    chk("idle_hit_score", int'(score), 1);
    chk("idle_hit_active", int'(shot_active), 0);
    // fire beats reload; low clamp
    player_x = 11'd20;
    pulse(1, 1, 0);
    tick();
    chk("both_active", int'(shot_active), 1);
    chk("both_ammo", int'(ammo), 2);
    chk("both_reloading", int'(reloading), 0);
    chk("clamp_lo", int'(shot_x), 97);
    pulse(0, 0, 1);
    tick();
    chk("h2_score", int'(score), 2);
    // high clamp
    player_x = 11'd900;
    pulse(1, 0, 0);
    tick();
    chk("clamp_hi", int'(shot_x), 784);
    chk("hi_ammo", int'(ammo), 1);
    pulse(0, 0, 1);
    tick();
    chk("h3_score", int'(score), 3);
    // no frame_tick: nothing moves
    pulse(1, 0, 0);
    repeat (10) @(negedge clk);
    chk("hold_active", int'(shot_active), 0);
    chk("hold_ammo", int'(ammo), 1);
    tick();
    chk("last_ammo", int'(ammo), 0);
    chk("last_active", int'(shot_active), 1);
    pulse(0, 0, 1);
    tick();
    chk("empty_reloading", int'(reloading), 1);
    chk("empty_score", int'(score), 4);
    chk("empty_active", int'(shot_active), 0);
    // dwell: 60 ticks, fire ignored throughout
    for (int k = 1; k <= 59; k++) begin
      if (k == 10) pulse(1, 0, 0);
      tick();
      chk("dwell_reloading", int'(reloading), 1);
      chk("dwell_ammo", int'(ammo), 0);
    end
    tick();
    chk("rel_done", int'(reloading), 0);
    chk("rel_ammo", int'(ammo), 5);
    chk("rel_fire_ignored", int'(shot_active), 0);
    // reset during flight
    pulse(1, 0, 0);
    tick();
    tick();
    chk("pre_rst_active", int'(shot_active), 1);
    chk("pre_rst_y", int'(shot_y), 485);
    do_reset();
    chk_reset_vals("rst_flight");
    reset = 1'b0;
    // manual reload, then reset during it
    pulse(1, 0, 0);
    tick();
    pulse(0, 0, 1);
    tick();
    chk("m_score", int'(score), 1);
    chk("m_ammo", int'(ammo), 4);
    pulse(0, 1, 0);
    tick();
    chk("manual_reloading", int'(reloading), 1);
    tick();
    tick();
    do_reset();
    chk_reset_vals("rst_reload");
    reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
